// File: rtl/mau_fill_unit.sv
// Line-fill unit: assembles one L1 line from BEATS sequential memory beats, one beat outstanding at a time.
// Optional MAU_FILL_LAST_LINE_EN: remembers the last completed line and answers repeat requests without memory traffic.
module mau_fill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_SIZE      = 256,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mau_req_val,
  input  logic [ADDR_WIDTH-1:0]     mau_req_addr,
  output logic                      mau_req_ack,
  output logic [LINE_SIZE-1:0]      mau_ack_data,
  output logic                      mem_req_val,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ack,
  input  logic                      mem_rsp_val,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int BEATS    = LINE_SIZE / MEM_DATA_WIDTH;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LINE_SIZE-1:0]    line_q, line_d;
  logic [ADDR_WIDTH-1:0]   reqBase;

  assign reqBase = mau_req_addr & LINE_MASK;

`ifdef MAU_FILL_LAST_LINE_EN
  // line_q still holds the last completed line: any fill that starts either completes
  // (retagging) or is killed by reset (clearing valid), so no separate line copy is needed.
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   tag_q, tag_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    line_d       = line_q;
    mem_req_val  = 1'b0;
    mem_req_addr = '0;
    mau_req_ack  = 1'b0;
    mau_ack_data = '0;
`ifdef MAU_FILL_LAST_LINE_EN
    valid_d      = valid_q;
    tag_d        = tag_q;
`endif
    case (state_q)
      IDLE: begin
        if (mau_req_val) begin
          base_d  = reqBase;
          beat_d  = '0;
          state_d = REQ;
`ifdef MAU_FILL_LAST_LINE_EN
          if (valid_q && (tag_q == reqBase)) begin
            state_d = ACK;
          end
`endif
        end
      end
      REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = base_q + ADDR_WIDTH'(beat_q) * BEAT_BYTES;
        if (mem_req_ack) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_val) begin
          line_d[int'(beat_q) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data;
          if (beat_q == LAST_BEAT) begin
            state_d = ACK;
`ifdef MAU_FILL_LAST_LINE_EN
            valid_d = 1'b1;
            tag_d   = base_q;
`endif
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = REQ;
          end
        end
      end
      ACK: begin
        mau_req_ack  = 1'b1;
        mau_ack_data = line_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mau_fill_unit.sv
// Self-checking bench for mau_fill_unit: memory model, scoreboard of expected acks, vector table plus corner sequences.
// Define MAU_FILL_LAST_LINE_EN for both files to exercise the last-line hit path.
module tb_mau_fill_unit;

  localparam int AW    = 32;
  localparam int LS    = 256;
  localparam int MDW   = 32;
  localparam int BEATS = LS / MDW;

  logic            clk;
  logic            rst_n;
  logic            mau_req_val;
  logic [AW-1:0]   mau_req_addr;
  logic            mau_req_ack;
  logic [LS-1:0]   mau_ack_data;
  logic            mem_req_val;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_ack;
  logic            mem_rsp_val;
  logic [MDW-1:0]  mem_rsp_data;

  mau_fill_unit #(.ADDR_WIDTH(AW), .LINE_SIZE(LS), .MEM_DATA_WIDTH(MDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mau_req_val  (mau_req_val),
    .mau_req_addr (mau_req_addr),
    .mau_req_ack  (mau_req_ack),
    .mau_ack_data (mau_ack_data),
    .mem_req_val  (mem_req_val),
    .mem_req_addr (mem_req_addr),
    .mem_req_ack  (mem_req_ack),
    .mem_rsp_val  (mem_rsp_val),
    .mem_rsp_data (mem_rsp_data)
  );

  typedef struct {
    int            cycle;
    logic [LS-1:0] line;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] expBase;
    logic [AW-1:0] stallAddr;
    int            stallCycles;
  } vec_t;

  exp_t          sb[$];
  logic [AW-1:0] memLog[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            monEn = 0;
  logic [AW-1:0] stallAddr = '0;
  int            stallLeft = 0;
  int            staleLeft = 0;
  bit            rspPending = 0;
  logic [AW-1:0] rspAddr = '0;
  bit            prevStalled = 0;
  logic [AW-1:0] prevAddr = '0;
  bit            lastValid = 0;
  logic [AW-1:0] lastBase = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MDW-1:0] memData(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5A00, ~a[15:0]};
  endfunction

  // Memory model: acks immediately unless the stall address is pending, responds one cycle after ack.
  always @(posedge clk) begin
    #1;
    mem_req_ack  = 1'b0;
    mem_rsp_val  = 1'b0;
    mem_rsp_data = '0;
    if (staleLeft > 0) begin
      mem_rsp_val  = 1'b1;
      mem_rsp_data = 32'hDEAD_BEEF;
      staleLeft    = staleLeft - 1;
    end else if (rspPending) begin
      mem_rsp_val  = 1'b1;
      mem_rsp_data = memData(rspAddr);
      rspPending   = 0;
    end
    if (mem_req_val === 1'b1) begin
      if (prevStalled) begin
        checks++;
        if (mem_req_addr !== prevAddr) begin
          errors++;
          $display("[TB] FAIL stall_addr_stable actual=%h required=%h", mem_req_addr, prevAddr);
        end
      end
      if (mem_req_addr == stallAddr && stallLeft > 0) begin
        stallLeft   = stallLeft - 1;
        prevStalled = 1;
        prevAddr    = mem_req_addr;
      end else begin
        mem_req_ack = 1'b1;
        rspPending  = 1;
        rspAddr     = mem_req_addr;
        memLog.push_back(mem_req_addr);
        prevStalled = 0;
      end
    end else begin
      prevStalled = 0;
    end
  end

  // Ack monitor: every ack must match the head of the scoreboard in cycle and data.
  always @(posedge clk) begin
    #1;
    if (monEn) begin
      if (mau_req_ack === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ack actual=1 required=0 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc != e.cycle) begin
            errors++;
            $display("[TB] FAIL ack_cycle actual=%0d required=%0d", cyc, e.cycle);
          end
          checks++;
          if (mau_ack_data !== e.line) begin
            errors++;
            $display("[TB] FAIL ack_data actual=%h required=%h", mau_ack_data, e.line);
          end
        end
      end else begin
        checks++;
        if (mau_ack_data !== '0) begin
          errors++;
          $display("[TB] FAIL idle_ack_data actual=%h required=0", mau_ack_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_mem_req_val"}, LS'(mem_req_val), '0);
    checkOutput({tag, "_mem_req_addr"}, LS'(mem_req_addr), '0);
    checkOutput({tag, "_mau_req_ack"}, LS'(mau_req_ack), '0);
    checkOutput({tag, "_mau_ack_data"}, mau_ack_data, '0);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW-1:0] expBase,
                               input logic [AW-1:0] stA, input int stN,
                               input bit keepHigh, input bit afterAck);
    logic [LS-1:0] line;
    bit            hit;
    bit            seen;
    int            lat;
    hit = 0;
`ifdef MAU_FILL_LAST_LINE_EN
    hit = lastValid && (lastBase == expBase);
`endif
    for (int k = 0; k < BEATS; k++) line[k*MDW +: MDW] = memData(expBase + AW'(4 * k));
    lat = hit ? 1 : 1 + 2 * BEATS + stN;
    memLog.delete();
    stallAddr = stA;
    stallLeft = stN;
    sb.push_back('{cycle: cyc + lat + int'(afterAck), line: line});
    mau_req_val  = 1'b1;
    mau_req_addr = addr;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (mau_req_ack === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout addr=%h actual=none required=ack", addr);
      sb.delete();
    end
    if (!keepHigh) mau_req_val = 1'b0;
    checkOutput("beat_count", LS'(memLog.size()), hit ? '0 : LS'(BEATS));
    if (!hit && memLog.size() > 0) checkOutput("first_beat_addr", LS'(memLog[0]), LS'(expBase));
    lastValid = 1;
    lastBase  = expBase;
    stallLeft = 0;
  endtask

  vec_t vecs[6];

  initial begin
    bit reached;
    vecs[0] = '{addr: 32'h0000_1040, expBase: 32'h0000_1040, stallAddr: 32'h0, stallCycles: 0};
    vecs[1] = '{addr: 32'h0000_107C, expBase: 32'h0000_1060, stallAddr: 32'h0, stallCycles: 0};
    vecs[2] = '{addr: 32'h0000_1040, expBase: 32'h0000_1040, stallAddr: 32'h0000_1048, stallCycles: 3};
    vecs[3] = '{addr: 32'h0000_1040, expBase: 32'h0000_1040, stallAddr: 32'h0, stallCycles: 0};
    vecs[4] = '{addr: 32'hABCD_EF13, expBase: 32'hABCD_EF00, stallAddr: 32'h0, stallCycles: 0};
    vecs[5] = '{addr: 32'h0000_001F, expBase: 32'h0000_0000, stallAddr: 32'h0, stallCycles: 0};

    rst_n        = 1'b0;
    mau_req_val  = 1'b0;
    mau_req_addr = '0;
    repeat (3) tick();
    checkQuiet("reset");
    rst_n = 1'b1;
    monEn = 1;
    tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].expBase, vecs[v].stallAddr, vecs[v].stallCycles, 0, 0);
      tick();
    end

    // Request held through ACK, then a new address presented straight after.
    applyStimulus(32'h0000_5040, 32'h0000_5040, '0, 0, 1, 0);
    applyStimulus(32'h0000_2000, 32'h0000_2000, '0, 0, 0, 1);
    tick();

    // Reset while waiting on beat 4, with stale responses arriving afterwards.
    memLog.delete();
    mau_req_val  = 1'b1;
    mau_req_addr = 32'h0000_3000;
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      if (memLog.size() >= 5) reached = 1;
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat4_timeout actual=%0d required=5", memLog.size());
    end
    mau_req_val = 1'b0;
    tick();
    rst_n     = 1'b0;
    staleLeft = 2;
    tick();
    checkQuiet("mid_reset");
    rst_n     = 1'b1;
    lastValid = 0;
    tick();
    checkQuiet("post_reset");
    tick();
    checkQuiet("post_stale");
    applyStimulus(32'h0000_3000, 32'h0000_3000, '0, 0, 0, 0);

    repeat (5) tick();
    checkOutput("scoreboard_empty", LS'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
